// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the digit-counter width helper.
package addsub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Width of the digit counter: clog2(width/digit), never less than 1.
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        int unsigned n;
        n = width / digit;
        if (n <= 1) begin
            return 1;
        end
        return 32'($clog2(n));
    endfunction

    localparam int unsigned CNT_W_DEFAULT = cnt_width(32, 8);

endpackage

// File: rtl/addsub_serial_digit_adder.sv
// digit_adder: DIGIT-bit ripple of full adders shared by every digit step.
// Ports:
//   a, b   - operand digits
//   cin    - carry into bit 0
//   sum    - digit sum
//   cout   - carry out of the top bit
//   c_msb  - carry into the top bit (used for signed overflow)
module digit_adder #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // Plain ripple chain; the carry vector lives inside the block.
    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock, LSB digit first, one op per start/done.
// Optional: define ADDSUB_SERIAL_FLAGS_EN to compute overflow and zero;
// otherwise both flags are tied to 0 and their registers are absent.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   start, sub, cin  - request, subtract select, carry/borrow in
//   a, b             - operands, sampled only on the accepting edge
//   busy, done       - RUN indicator, one-cycle completion pulse
//   result, cout     - sum/difference and carry (sub: 1 = no borrow)
//   overflow, zero   - signed overflow and zero-result flags
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = cnt_width(WIDTH, DIGIT);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   dsum;
    logic               dcout;
    logic               msb_carry;
    logic [WIDTH-1:0]   acc_next;
    logic               last_digit;

`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic               ov_q, ov_d;
    logic               zero_q, zero_d;
`else
    logic               unused_msb_carry;
    assign unused_msb_carry = msb_carry;
`endif

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (c_q),
        .sum   (dsum),
        .cout  (dcout),
        .c_msb (msb_carry)
    );

    // New digit enters from the MSB side; after N steps acc holds the result.
    assign acc_next   = WIDTH'({dsum, acc_q} >> DIGIT);
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef ADDSUB_SERIAL_FLAGS_EN
        ov_d     = ov_q;
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + ~borrow.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? ~cin : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                c_d   = dcout;
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = acc_next;
                if (last_digit) begin
                    result_d = acc_next;
                    cout_d   = dcout;
                    done_d   = 1'b1;
                    state_d  = DONE;
`ifdef ADDSUB_SERIAL_FLAGS_EN
                    ov_d     = msb_carry ^ dcout;
                    zero_d   = (acc_next == '0);
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef ADDSUB_SERIAL_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            ov_q   <= ov_d;
            zero_q <= zero_d;
        end
    end

    assign overflow = ov_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: DIGIT=8, 32 and 1 instances against an
// arithmetic reference model. Honours ADDSUB_SERIAL_FLAGS_EN.
module tb_addsub_serial;

    localparam int unsigned W = 32;
`ifdef ADDSUB_SERIAL_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;
    localparam longint TWO32 = 64'sh1_0000_0000;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start_v;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;

    logic start8, start32, start1;
    assign start8  = start_v && (sel == 0);
    assign start32 = start_v && (sel == 1);
    assign start1  = start_v && (sel == 2);

    logic busy8, done8, cout8, ov8, z8;
    logic busy32, done32, cout32, ov32, z32;
    logic busy1, done1, cout1, ov1, z1;
    logic [W-1:0] res8, res32, res1;

    logic busy_s, done_s, cout_s, ov_s, z_s;
    logic [W-1:0] res_s;

    int errors = 0;
    int checks = 0;

    addsub_serial #(.WIDTH(W), .DIGIT(8)) u_dut (
        .clk(clk), .reset(reset), .start(start8), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy8), .done(done8), .result(res8),
        .cout(cout8), .overflow(ov8), .zero(z8));

    addsub_serial #(.WIDTH(W), .DIGIT(32)) u_d32 (
        .clk(clk), .reset(reset), .start(start32), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy32), .done(done32), .result(res32),
        .cout(cout32), .overflow(ov32), .zero(z32));

    addsub_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy1), .done(done1), .result(res1),
        .cout(cout1), .overflow(ov1), .zero(z1));

    always_comb begin
        case (sel)
            1:       {busy_s, done_s, res_s, cout_s, ov_s, z_s} = {busy32, done32, res32, cout32, ov32, z32};
            2:       {busy_s, done_s, res_s, cout_s, ov_s, z_s} = {busy1, done1, res1, cout1, ov1, z1};
            default: {busy_s, done_s, res_s, cout_s, ov_s, z_s} = {busy8, done8, res8, cout8, ov8, z8};
        endcase
    end

    // Reference: exact integer arithmetic, then reduce modulo 2^32.
    function automatic logic [W+2:0] model(input op_t op);
        longint ua, ub, sa, sb, uc, u, s;
        logic [W-1:0] r;
        logic co, ov, z;
        ua = op.a;
        ub = op.b;
        sa = longint'($signed(op.a));
        sb = longint'($signed(op.b));
        uc = op.cin;
        if (!op.sub) begin
            u  = ua + ub + uc;
            s  = sa + sb + uc;
            co = (u >= TWO32);
        end else begin
            u  = ua - ub - uc;
            s  = sa - sb - uc;
            co = (u >= 0);
        end
        r  = u[W-1:0];
        ov = FLAGS_EN && (s > SMAX || s < SMIN);
        z  = FLAGS_EN && (r == '0);
        return {r, co, ov, z};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t op;
        op.a   = pick_operand();
        op.b   = pick_operand();
        op.sub = 1'($urandom_range(0, 1));
        op.cin = 1'($urandom_range(0, 1));
        return op;
    endfunction

    // Issue one op on instance s; returns cycles from start edge to done.
    task automatic run_op(input int s, input op_t op, output int lat);
        @(negedge clk);
        sel = s; a = op.a; b = op.b; sub = op.sub; cin = op.cin;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        a = $urandom; b = $urandom; sub = ~op.sub; cin = ~op.cin;
        checks++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b done=%b required busy=1 done=0", busy_s, done_s);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done_s !== 1'b1 && lat < 100);
    endtask

    task automatic test_reset();
        reset = 1'b1; start_v = 1'b0; sel = 0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        #12;
        checks++;
        if ({busy8, done8, res8, cout8, ov8, z8} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h cout=%b ov=%b z=%b required all 0",
                     busy8, done8, res8, cout8, ov8, z8);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        op_t tbl[7];
        int lat;
        logic [W+2:0] exp;
        tbl[0] = '{a: 32'd5,          b: 32'd3, sub: 1'b1, cin: 1'b0};
        tbl[1] = '{a: 32'd3,          b: 32'd5, sub: 1'b1, cin: 1'b0};
        tbl[2] = '{a: 32'd5,          b: 32'd5, sub: 1'b1, cin: 1'b0};
        tbl[3] = '{a: 32'h7FFF_FFFF,  b: 32'd1, sub: 1'b0, cin: 1'b0};
        tbl[4] = '{a: 32'hFFFF_FFFF,  b: 32'd0, sub: 1'b0, cin: 1'b1};
        tbl[5] = '{a: 32'h8000_0000,  b: 32'd1, sub: 1'b1, cin: 1'b0};
        tbl[6] = '{a: 32'd7,          b: 32'd7, sub: 1'b1, cin: 1'b1};
        foreach (tbl[i]) begin
            run_op(0, tbl[i], lat);
            exp = model(tbl[i]);
            checks++;
            if (lat != 4) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required 4", i, lat);
            end
            checks++;
            if ({res_s, cout_s, ov_s, z_s} !== exp) begin
                errors++;
                $display("FAIL directed_result[%0d]: got res=%h cout=%b ov=%b z=%b required res=%h cout=%b ov=%b z=%b",
                         i, res_s, cout_s, ov_s, z_s, exp[W+2:3], exp[2], exp[1], exp[0]);
            end
        end
        // Done must be a single-cycle pulse.
        @(negedge clk);
        checks++;
        if (done_s !== 1'b0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b busy=%b required 0 0", done_s, busy_s);
        end
    endtask

    task automatic test_random();
        op_t op;
        int lat;
        logic [W+2:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = rand_op();
            run_op(0, op, lat);
            exp = model(op);
            checks++;
            if (lat != 4 || {res_s, cout_s, ov_s, z_s} !== exp) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h sub=%b cin=%b got lat=%0d res=%h flags=%b required lat=4 res=%h flags=%b",
                         i, op.a, op.b, op.sub, op.cin, lat, res_s, {cout_s, ov_s, z_s}, exp[W+2:3], exp[2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t op1, op2, op3;
        int lat, gap;
        logic [W+2:0] exp;
        op1 = '{a: 32'h1234_5678, b: 32'h0000_1111, sub: 1'b0, cin: 1'b0};
        op2 = '{a: 32'hDEAD_BEEF, b: 32'hCAFE_F00D, sub: 1'b1, cin: 1'b1};
        op3 = '{a: 32'h0000_0010, b: 32'h0000_0020, sub: 1'b1, cin: 1'b0};
        @(negedge clk);
        sel = 0; a = op1.a; b = op1.b; sub = op1.sub; cin = op1.cin; start_v = 1'b1;
        @(negedge clk);
        a = op2.a; b = op2.b; sub = op2.sub; cin = op2.cin;
        @(negedge clk);
        start_v = 1'b0;
        lat = 1;
        while (done_s !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        exp = model(op1);
        checks++;
        if (lat != 4 || {res_s, cout_s, ov_s, z_s} !== exp) begin
            errors++;
            $display("FAIL restart_ignored: got lat=%0d res=%h flags=%b required lat=4 res=%h flags=%b",
                     lat, res_s, {cout_s, ov_s, z_s}, exp[W+2:3], exp[2:0]);
        end
        // Start asserted during the DONE cycle.
        a = op3.a; b = op3.b; sub = op3.sub; cin = op3.cin; start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        checks++;
        if (done_s !== 1'b0 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL accept_in_done: done=%b busy=%b required 0 1", done_s, busy_s);
        end
        gap = 1;
        while (done_s !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        exp = model(op3);
        checks++;
        if (gap != 5 || {res_s, cout_s, ov_s, z_s} !== exp) begin
            errors++;
            $display("FAIL back_to_back: got gap=%0d res=%h flags=%b required gap=5 res=%h flags=%b",
                     gap, res_s, {cout_s, ov_s, z_s}, exp[W+2:3], exp[2:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        op_t op;
        int lat, bad;
        logic [W+2:0] exp;
        op = '{a: 32'd5, b: 32'd3, sub: 1'b1, cin: 1'b0};
        run_op(0, op, lat);
        @(negedge clk);
        sel = 0; a = 32'h0F0F_0F0F; b = 32'h0101_0101; sub = 1'b0; cin = 1'b0;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, res8, cout8, ov8, z8} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b res=%h cout=%b required all 0",
                     busy8, done8, res8, cout8);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_done_after_abort: got %0d active cycles required 0", bad);
        end
        op = '{a: 32'h0000_00FF, b: 32'h0000_0001, sub: 1'b0, cin: 1'b1};
        run_op(0, op, lat);
        exp = model(op);
        checks++;
        if (lat != 4 || {res_s, cout_s, ov_s, z_s} !== exp) begin
            errors++;
            $display("FAIL fresh_after_reset: got lat=%0d res=%h required lat=4 res=%h", lat, res_s, exp[W+2:3]);
        end
    endtask

    task automatic test_digit_widths();
        op_t op;
        int lat, want;
        logic [W+2:0] exp;
        for (int s = 1; s <= 2; s++) begin
            want = (s == 1) ? 1 : 32;
            for (int i = 0; i < 6; i++) begin
                if (i == 0) op = '{a: 32'd5, b: 32'd3, sub: 1'b1, cin: 1'b0};
                else        op = rand_op();
                run_op(s, op, lat);
                exp = model(op);
                checks++;
                if (lat != want || {res_s, cout_s, ov_s, z_s} !== exp) begin
                    errors++;
                    $display("FAIL digit_width[sel%0d,%0d]: a=%h b=%h sub=%b got lat=%0d res=%h flags=%b required lat=%0d res=%h flags=%b",
                             s, i, op.a, op.b, op.sub, lat, res_s, {cout_s, ov_s, z_s}, want, exp[W+2:3], exp[2:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_widths();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
